reg_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one controlling-register bus (address / write_enable / write_data / read_enable / read_data) between NUM_MASTERS requesters (CPU, debug, DMA, ...).
- Serialises accesses as fixed 3-cycle transactions: arbitrate, issue, respond.
- Registers every downstream strobe so the register block sees clean single-cycle pulses.
- Sits between the master-side interconnect and the controlling register block.

---
 rtl/reg_bus_arbiter_pkg.sv | 19 +
 rtl/reg_bus_arbiter_if.sv | 43 ++++
 rtl/reg_bus_arbiter_rr_pick.sv | 34 +++
 rtl/reg_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_reg_bus_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and defaults for the register-bus arbiter slice.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;

  // Next round-robin position after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Master-side requests plus downstream register bus, bundled for the arbiter.
// Optional m_lock member exists only when REG_BUS_ARB_LOCK_EN is defined.
interface reg_bus_arbiter_if
  import reg_bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
);
  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS-1:0]            m_we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]            m_gnt;
  logic [NUM_MASTERS-1:0]            m_ack;
  logic [DATA_WIDTH-1:0]             m_rdata;
  logic [ADDR_WIDTH-1:0]             address;
  logic                              write_enable;
  logic [DATA_WIDTH-1:0]             write_data;
  logic                              read_enable;
  logic [DATA_WIDTH-1:0]             read_data;
`ifdef REG_BUS_ARB_LOCK_EN
  logic [NUM_MASTERS-1:0]            m_lock;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_lock, read_data,
    output m_gnt, m_ack, m_rdata, address, write_enable, write_data, read_enable
  );
  modport master (
    output m_req, m_we, m_addr, m_wdata, m_lock, read_data,
    input  m_gnt, m_ack, m_rdata, address, write_enable, write_data, read_enable
  );
`else
  modport slave (
    input  m_req, m_we, m_addr, m_wdata, read_data,
    output m_gnt, m_ack, m_rdata, address, write_enable, write_data, read_enable
  );
  modport master (
    output m_req, m_we, m_addr, m_wdata, read_data,
    input  m_gnt, m_ack, m_rdata, address, write_enable, write_data, read_enable
  );
`endif
endinterface

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at index >= ptr, wrapping.
module rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] onehot,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  // Search upward from ptr first, then fall back to the lowest index below it.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!valid && req[i] && (IDX_W'(i) >= ptr)) begin
        valid     = 1'b1;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!valid && req[i]) begin
        valid     = 1'b1;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter serialising masters onto one register bus as fixed
// 3-cycle transactions (arbitrate, issue, respond) with registered strobes.
// Optional grant locking is compiled in with REG_BUS_ARB_LOCK_EN.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input logic              clock,
  input logic              reset,
  reg_bus_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_vld;
  logic [NUM_MASTERS-1:0] grant_oh;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_vld;
  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
`ifdef REG_BUS_ARB_LOCK_EN
  logic                   locked;
`endif

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req   (bus.m_req),
    .ptr   (ptr),
    .onehot(pick_oh),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  // A locked winner still requesting bypasses arbitration; otherwise round-robin.
  always_comb begin
    grant_oh  = pick_oh;
    grant_idx = pick_idx;
    grant_vld = pick_vld;
`ifdef REG_BUS_ARB_LOCK_EN
    if (locked && bus.m_req[win_idx]) begin
      grant_oh  = NUM_MASTERS'(1) << win_idx;
      grant_idx = win_idx;
      grant_vld = 1'b1;
    end
`endif
  end

  // Mux the granted master's command fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_oh[i]) begin
        sel_we    = bus.m_we[i];
        sel_addr  = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Transaction sequencer; every bus-facing output is a register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      ptr              <= '0;
      win_idx          <= '0;
      bus.m_gnt        <= '0;
      bus.m_ack        <= '0;
      bus.m_rdata      <= '0;
      bus.address      <= '0;
      bus.write_enable <= 1'b0;
      bus.write_data   <= '0;
      bus.read_enable  <= 1'b0;
`ifdef REG_BUS_ARB_LOCK_EN
      locked           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef REG_BUS_ARB_LOCK_EN
          locked <= 1'b0;
`endif
          if (grant_vld) begin
            bus.m_gnt        <= grant_oh;
            win_idx          <= grant_idx;
            bus.address      <= sel_addr;
            bus.write_data   <= sel_wdata;
            bus.write_enable <= sel_we;
            bus.read_enable  <= !sel_we;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          bus.m_rdata      <= bus.write_enable ? '0 : bus.read_data;
          bus.m_ack        <= bus.m_gnt;
          bus.address      <= '0;
          bus.write_data   <= '0;
          bus.write_enable <= 1'b0;
          bus.read_enable  <= 1'b0;
          state            <= RESP;
        end
        RESP: begin
          bus.m_ack <= '0;
          bus.m_gnt <= '0;
`ifdef REG_BUS_ARB_LOCK_EN
          locked    <= bus.m_lock[win_idx];
          if (!bus.m_lock[win_idx])
            ptr <= IDX_W'(wrap_inc(int'(win_idx), NUM_MASTERS));
`else
          ptr       <= IDX_W'(wrap_inc(int'(win_idx), NUM_MASTERS));
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: vector table of single transactions
// plus hand-written multi-master, drop, reset and lock sequences.
module tb_reg_bus_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  reg_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Register-block model: one fixed register, otherwise address-derived data.
  assign bus.read_data = (bus.address == 32'h0000_00AA) ? 32'h0000_1234
                                                         : (bus.address ^ 32'hDEAD_0000);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_master(input int i, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    bus.m_we[i]              = we;
    bus.m_addr[i*AW +: AW]   = addr;
    bus.m_wdata[i*DW +: DW]  = wdata;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic run_single(input vec_t v, input logic [31:0] prev_rd);
    logic [3:0] oh;
    oh = 4'(1) << v.mst;
    set_master(v.mst, v.we, v.addr, v.wdata);
    bus.m_req[v.mst] = 1'b1;
    tick();
    chk("vec_gnt",       bus.m_gnt, oh);
    chk("vec_we",        bus.write_enable, v.we);
    chk("vec_re",        bus.read_enable, !v.we);
    chk("vec_addr",      bus.address, v.addr);
    if (v.we) chk("vec_wdata", bus.write_data, v.wdata);
    chk("vec_rd_hold",   bus.m_rdata, prev_rd);
    chk("vec_ack_early", bus.m_ack, 4'h0);
    tick();
    chk("vec_ack",       bus.m_ack, oh);
    chk("vec_rdata",     bus.m_rdata, v.exp_rd);
    chk("vec_strobe_off", {bus.write_enable, bus.read_enable}, 2'b00);
    chk("vec_addr_idle", bus.address, 32'h0);
    bus.m_req[v.mst] = 1'b0;
    tick();
    chk("vec_ack_clr",   bus.m_ack, 4'h0);
    chk("vec_gnt_clr",   bus.m_gnt, 4'h0);
  endtask

  initial begin
    logic [31:0] prev;
    int          w;
    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{mst: 2, we: 1'b0, addr: 32'h0000_00AA, wdata: 32'h0,         exp_rd: 32'h0000_1234};
    vecs[1] = '{mst: 0, we: 1'b1, addr: 32'h0000_0055, wdata: 32'h1,         exp_rd: 32'h0};
    vecs[2] = '{mst: 1, we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0,         exp_rd: 32'hDEAD_0010};
    vecs[3] = '{mst: 3, we: 1'b1, addr: 32'hFFFF_FFFF, wdata: 32'hA5A5_A5A5, exp_rd: 32'h0};
    vecs[4] = '{mst: 3, we: 1'b0, addr: 32'h0000_0000, wdata: 32'h0,         exp_rd: 32'hDEAD_0000};

    bus.m_req   = '0;
    bus.m_we    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
`ifdef REG_BUS_ARB_LOCK_EN
    bus.m_lock  = '0;
`endif
    reset = 1'b0;
    tick();
    tick();
    chk("rst_gnt",   bus.m_gnt, 4'h0);
    chk("rst_ack",   bus.m_ack, 4'h0);
    chk("rst_rdata", bus.m_rdata, 32'h0);
    chk("rst_addr",  bus.address, 32'h0);
    chk("rst_we",    bus.write_enable, 1'b0);
    chk("rst_re",    bus.read_enable, 1'b0);
    chk("rst_wdata", bus.write_data, 32'h0);
    reset = 1'b1;

    // Table of isolated single-master transactions.
    prev = 32'h0;
    for (int k = 0; k < 5; k++) begin
      run_single(vecs[k], prev);
      prev = vecs[k].exp_rd;
    end

    // All four masters requesting continuously: 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NM; i++) set_master(i, 1'b0, 32'h100 * i + 32'h4, 32'h0);
    bus.m_req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      w = n % NM;
      tick();
      chk("rr_gnt",  bus.m_gnt, 4'(1) << w);
      chk("rr_strb", {bus.write_enable, bus.read_enable}, 2'b01);
      chk("rr_addr", bus.address, 32'h100 * w + 32'h4);
      tick();
      chk("rr_ack",   bus.m_ack, 4'(1) << w);
      chk("rr_rdata", bus.m_rdata, (32'h100 * w + 32'h4) ^ 32'hDEAD_0000);
      tick();
      chk("rr_idle", {bus.m_ack, bus.write_enable, bus.read_enable}, 6'h0);
    end
    bus.m_req = '0;

    // Master 1 drops its request mid-transaction; master 2 is next.
    do_reset();
    set_master(1, 1'b0, 32'h20, 32'h0);
    set_master(2, 1'b0, 32'h30, 32'h0);
    bus.m_req = 4'b0110;
    tick();
    chk("drop_gnt1", bus.m_gnt, 4'b0010);
    bus.m_req[1] = 1'b0;
    tick();
    chk("drop_ack1",   bus.m_ack, 4'b0010);
    chk("drop_rdata1", bus.m_rdata, 32'hDEAD_0020);
    tick();
    tick();
    chk("drop_gnt2", bus.m_gnt, 4'b0100);
    chk("drop_addr2", bus.address, 32'h30);
    tick();
    chk("drop_ack2", bus.m_ack, 4'b0100);
    bus.m_req[2] = 1'b0;
    tick();

    // Reset during ISSUE clears outputs asynchronously and the pointer.
    set_master(0, 1'b0, 32'h40, 32'h0);
    set_master(3, 1'b0, 32'h70, 32'h0);
    bus.m_req = 4'b1101;
    tick();
    chk("rsti_gnt", bus.m_gnt, 4'b1000);
    chk("rsti_re",  bus.read_enable, 1'b1);
    reset = 1'b0;
    #1;
    chk("rsti_async_gnt",   bus.m_gnt, 4'h0);
    chk("rsti_async_re",    bus.read_enable, 1'b0);
    chk("rsti_async_addr",  bus.address, 32'h0);
    chk("rsti_async_rdata", bus.m_rdata, 32'h0);
    chk("rsti_async_ack",   bus.m_ack, 4'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("rsti_regnt", bus.m_gnt, 4'b0001);
    chk("rsti_addr",  bus.address, 32'h40);
    tick();
    chk("rsti_ack", bus.m_ack, 4'b0001);
    bus.m_req = '0;
    tick();

`ifdef REG_BUS_ARB_LOCK_EN
    // Master 3 holds the bus for three locked writes while master 0 waits.
    do_reset();
    set_master(0, 1'b0, 32'h10, 32'h0);
    bus.m_lock[3] = 1'b1;
    bus.m_req[3]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_master(3, 1'b1, 32'h300, 32'hC0DE_0000 + k);
      tick();
      chk("lock_gnt3",  bus.m_gnt, 4'b1000);
      chk("lock_we",    bus.write_enable, 1'b1);
      chk("lock_wdata", bus.write_data, 32'hC0DE_0000 + k);
      if (k == 0) bus.m_req[0] = 1'b1;
      if (k == 2) bus.m_lock[3] = 1'b0;
      tick();
      chk("lock_ack3",  bus.m_ack, 4'b1000);
      chk("lock_rdata", bus.m_rdata, 32'h0);
      if (k == 2) bus.m_req[3] = 1'b0;
      tick();
    end
    tick();
    chk("lock_gnt0", bus.m_gnt, 4'b0001);
    tick();
    chk("lock_ack0", bus.m_ack, 4'b0001);
    bus.m_req = '0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
